// File: rtl/counter_sequencer_pkg.sv
// counter_sequencer_pkg
//   Shared encodings for the counter sequencer: counter mode codes, FSM state
//   codes, and the field widths of a queued command record {mode, data, len}.
package counter_sequencer_pkg;

  localparam int MODE_W = 2;
  localparam int DATA_W = 4;

  // Counter mode codes driven on cnt_mode
  localparam logic [MODE_W-1:0] MODE_UP   = 2'b00;
  localparam logic [MODE_W-1:0] MODE_DOWN = 2'b01;
  localparam logic [MODE_W-1:0] MODE_UP3  = 2'b10;
  localparam logic [MODE_W-1:0] MODE_LOAD = 2'b11;

  // Sequencer FSM states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Width of one packed command record {mode, data, len}
  function automatic int rec_width(input int len_w);
    return MODE_W + DATA_W + len_w;
  endfunction

endpackage

// File: rtl/counter_sequencer_if.sv
// counter_sequencer_if
//   Command channel of the sequencer (valid/ready handshake).
//   cmd_valid  : command offered by the producer
//   cmd_ready  : sequencer can accept a command this cycle
//   cmd_mode   : counter mode for the command
//   cmd_data   : load value (mode LOAD only)
//   cmd_len    : number of counter steps to run
interface counter_sequencer_if
  import counter_sequencer_pkg::*;
#(
  parameter int LEN_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [MODE_W-1:0] cmd_mode;
  logic [DATA_W-1:0] cmd_data;
  logic [LEN_W-1:0]  cmd_len;

  modport master (output cmd_valid, cmd_mode, cmd_data, cmd_len, input cmd_ready);
  modport slave  (input cmd_valid, cmd_mode, cmd_data, cmd_len, output cmd_ready);
endinterface

// File: rtl/counter_sequencer_cmd_fifo.sv
// counter_sequencer_cmd_fifo
//   Synchronous command FIFO with synchronous flush.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_flush        : empty the FIFO at the next edge (push ignored)
//   i_push/i_wdata : write request and data (ignored when full)
//   i_pop          : read request (ignored when empty)
//   o_rdata        : head entry
//   o_full/o_empty : occupancy flags
module counter_sequencer_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 14
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_wr;
  logic             w_rd;

  // Pointers carry one extra wrap bit to tell full from empty
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_rdata = r_mem[r_rptr[AW-1:0]];
  assign w_wr    = i_push && !o_full && !i_flush;
  assign w_rd    = i_pop && !o_empty && !i_flush;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/counter_sequencer.sv
// counter_sequencer
//   Queues counter commands and drives the 4-bit multi-mode counter for
//   exactly the requested number of clocks, freezing it in between.
//   i_clk, i_reset          : clock, synchronous active-high reset
//   cmd_if (slave)          : command channel {mode, data, len}
//   i_abort                 : flush queue, cancel run, zero counter
//   o_cnt_enable/mode/D/reset : counter controls
//   i_cnt_rco/load/Q        : counter status
//   o_busy, o_done          : activity flag, per-command completion pulse
//   o_rco_count, o_last_q   : results of the last completed command
//   o_err                   : sticky unconfirmed-load flag
module counter_sequencer
  import counter_sequencer_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int LEN_W     = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  counter_sequencer_if.slave cmd_if,
  input  logic              i_abort,
  output logic              o_cnt_enable,
  output logic [MODE_W-1:0] o_cnt_mode,
  output logic [DATA_W-1:0] o_cnt_D,
  output logic              o_cnt_reset,
  input  logic              i_cnt_rco,
  input  logic              i_cnt_load,
  input  logic [DATA_W-1:0] i_cnt_Q,
  output logic              o_busy,
  output logic              o_done,
  output logic [LEN_W-1:0]  o_rco_count,
  output logic [DATA_W-1:0] o_last_q,
  output logic              o_err
);
  localparam int REC_W = rec_width(LEN_W);

  logic              w_full;
  logic              w_empty;
  logic              w_ready;
  logic              w_push;
  logic              w_pop;
  logic              w_run;
  logic [REC_W-1:0]  w_wdata;
  logic [REC_W-1:0]  w_head;
  logic [MODE_W-1:0] w_head_mode;
  logic [DATA_W-1:0] w_head_data;
  logic [LEN_W-1:0]  w_head_len;
  logic [LEN_W-1:0]  w_head_len_eff;

  logic [1:0]        r_state;
  logic [MODE_W-1:0] r_mode;
  logic [DATA_W-1:0] r_data;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_step;
  logic [LEN_W-1:0]  r_acc;
  logic              r_prev_run;
  logic [LEN_W-1:0]  r_rco_count;
  logic [DATA_W-1:0] r_last_q;
  logic              r_err;

  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    return (&v) ? v : v + LEN_W'(1);
  endfunction

  assign w_ready = !w_full && !i_abort;
  assign w_push  = cmd_if.cmd_valid && w_ready;
  assign w_pop   = (r_state == ST_IDLE) && !w_empty && !i_abort;
  assign w_wdata = {cmd_if.cmd_mode, cmd_if.cmd_data, cmd_if.cmd_len};

  assign cmd_if.cmd_ready = w_ready;

  counter_sequencer_cmd_fifo #(
    .DEPTH (CMD_DEPTH),
    .WIDTH (REC_W)
  ) u_cmd_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_flush (i_abort),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_head_mode = w_head[REC_W-1 -: MODE_W];
  assign w_head_data = w_head[LEN_W +: DATA_W];
  assign w_head_len  = w_head[LEN_W-1:0];
  // A load is a single step; a zero length still runs one step
  assign w_head_len_eff = (w_head_mode == MODE_LOAD || w_head_len == '0) ? LEN_W'(1) : w_head_len;

  // Outside RUN the counter reloads its own Q, which freezes it
  assign w_run        = (r_state == ST_RUN) && !i_reset && !i_abort;
  assign o_cnt_enable = w_run;
  assign o_cnt_mode   = w_run ? r_mode : MODE_LOAD;
  assign o_cnt_D      = w_run ? r_data : i_cnt_Q;
  assign o_cnt_reset  = i_reset | i_abort;
  assign o_busy       = !i_reset && ((r_state != ST_IDLE) || !w_empty);
  assign o_done       = !i_reset && !i_abort && (r_state == ST_DONE);
  assign o_rco_count  = r_rco_count;
  assign o_last_q     = r_last_q;
  assign o_err        = r_err;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_mode      <= '0;
      r_data      <= '0;
      r_len       <= '0;
      r_step      <= '0;
      r_acc       <= '0;
      r_prev_run  <= 1'b0;
      r_rco_count <= '0;
      r_last_q    <= '0;
      r_err       <= 1'b0;
    end else if (i_abort) begin
      r_state    <= ST_IDLE;
      r_mode     <= '0;
      r_data     <= '0;
      r_len      <= '0;
      r_step     <= '0;
      r_acc      <= '0;
      r_prev_run <= 1'b0;
    end else begin
      r_prev_run <= (r_state == ST_RUN);
      // Counter outputs lag by one clock, so rco is sampled one cycle after each RUN cycle
      if (r_prev_run && i_cnt_rco) r_acc <= sat_inc(r_acc);
      case (r_state)
        ST_IDLE: begin
          r_step <= '0;
          r_acc  <= '0;
          if (!w_empty) begin
            r_mode  <= w_head_mode;
            r_data  <= w_head_data;
            r_len   <= w_head_len_eff;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (r_step == r_len - LEN_W'(1)) r_state <= ST_DRAIN;
          else                             r_step  <= r_step + LEN_W'(1);
        end
        ST_DRAIN: begin
          r_last_q    <= i_cnt_Q;
          r_rco_count <= i_cnt_rco ? sat_inc(r_acc) : r_acc;
          if (r_mode == MODE_LOAD && (i_cnt_Q != r_data || !i_cnt_load)) r_err <= 1'b1;
          r_state <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Command-driven controller for the 4-bit multi-mode counter (up, down, up-by-3, load). It accepts queued commands (mode, load data, cycle count) over a valid/ready interface and drives the counter's mode/D/reset inputs for exactly the requested number of clocks. Between commands it freezes the counter. It monitors rco/load/Q and reports per-command results.

## Interface
Parameters:
- CMD_DEPTH, 4: command FIFO entries (power of 2, ≥2).
- LEN_W, 8: width of cmd_len and rco_count.

Ports:
- clk  in  1: single clock, rising edge.
- reset  in  1: synchronous, active-high; clears all state.
- cmd_valid  in  1: command offered.
- cmd_ready  out  1: FIFO can accept; `!full && !abort`.
- cmd_mode  in  2: 00 up, 01 down, 10 up-by-3, 11 load.
- cmd_data  in  4: load value; used only in mode 11.
- cmd_len  in  LEN_W: counter steps to run; 0 treated as 1; forced to 1 for mode 11.
- abort  in  1: flush the queue, cancel the run, zero the counter.
- cnt_enable  out  1: high only in RUN.
- cnt_mode  out  2: to counter mode.
- cnt_D  out  4: to counter D.
- cnt_reset  out  1: to counter reset; `reset | abort`.
- cnt_rco, cnt_load  in  1 each: from counter.
- cnt_Q  in  4: from counter.
- busy  out  1: state ≠ IDLE or FIFO non-empty.
- done  out  1: one-cycle pulse per completed command.
- rco_count  out  LEN_W: rco pulses seen during the last command; saturates at all-ones.
- last_q  out  4: counter value at the end of the last command.
- err  out  1: sticky; a load was not confirmed.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: if the FIFO is non-empty, pop the head into the active registers (mode, data, len) and go to RUN. Clear the step counter and rco accumulator.
- RUN: drive cnt_mode = active mode, cnt_D = active data, and cnt_enable = 1. Stay for exactly len cycles, then go to DRAIN.
- DRAIN: capture cnt_Q into last_q. For mode 11, set err if `cnt_Q != data || !cnt_load`. Go to DONE.
- DONE: done = 1 and rco_count updates. Go to IDLE.
- Hold: in IDLE, DRAIN and DONE, drive cnt_mode = 11 and cnt_D = cnt_Q. The counter reloads its own value, so Q is frozen. The counter advances every clock regardless of enable; this hold is the freeze mechanism. The combinational path cnt_Q→cnt_D is legal because the counter's Q is registered.
- rco accumulation: count cnt_rco in every cycle whose previous state was RUN, i.e. RUN cycles 2..len plus DRAIN. This covers the one-cycle lag of the counter's registered outputs.
- Abort (any state): next state IDLE; FIFO emptied; active registers cleared; cnt_reset = 1 in that cycle, so Q = 0 at the next edge. No done is issued; rco_count and last_q are not updated.
- Abort with cmd_valid in the same cycle: cmd_ready = 0, so the push is dropped.
- FIFO full: cmd_ready = 0, even if a pop happens in the same cycle.
- Push into an empty FIFO while in IDLE: the entry is visible next cycle. There is no bypass.

## Timing
- Reset values:
  - State IDLE, FIFO empty.
  - cmd_ready = 1, busy = 0, done = 0, err = 0.
  - rco_count = 0, last_q = 0, cnt_enable = 0.
  - cnt_mode = 11, cnt_D = cnt_Q, cnt_reset = 1 during reset.
- Latency from push accepted at edge t:
  - pop at t+1;
  - RUN cycles t+2 … t+1+len;
  - DRAIN at t+2+len;
  - done high during t+3+len.
- Back-to-back commands: 3 idle/overhead cycles between RUN windows (DRAIN, DONE, IDLE).
- Reset mid-operation behaves like abort, and additionally clears err, rco_count and last_q.
- rco_count saturates at 2^LEN_W−1.

## Structure
- Package counter_sequencer_pkg: mode encodings (MODE_UP, MODE_DOWN, MODE_UP3, MODE_LOAD), FSM state encoding, and the command record layout {mode, data, len}.
- Sub-module cmd_fifo: synchronous FIFO of depth CMD_DEPTH with synchronous flush. Its width is 2+4+LEN_W.
- The bench pairs the block with the existing counter model.

## Test plan
- Reset, then push load D=4'hC at edge t → done at t+4; last_q = C; err = 0; Q stays C for 10 idle cycles.
- Load 0, then up with len=20 → rco_count = 1; last_q = 4.
- Load 5, then down with len=5 → rco_count = 1 (Q reaches 0 on the 5th step); last_q = 0.
- Load 0, then up-by-3 with len=5 → Q sequence 3, 6, 9, 12, 15; rco_count = 1; last_q = 15. Then up with len=0 → runs 1 step; last_q = 0.
- Up with len=200 in progress; push 4 more commands → all 4 accepted; a 5th push sees cmd_ready = 0. Assert abort at step 50 → next cycle Q = 0, busy = 0, no done, FIFO empty.
- Counter model forced to ignore D on a load of 4'h9 → err = 1 after DRAIN. err stays 1 through later commands until reset.
